mem_stage: RTL and testbench

//  MEM stage that consumes the EX/MEM pipeline register and produces the MEM/WB register.
//  - Resolves branches toward fetch (PCSrc, PCBranch).
//  - Runs loads and stores over a req/ack data-memory port; stalls the pipeline while an access is pending.
//  - Registers results into MEM/WB; a per-access timeout FSM flags dead memory.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_stage_mem_wb_reg.sv | 46 ++++
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access FSM encoding and
// the MEM/WB write-back control word with its bubble value.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_CTRL_BUBBLE = '{memtoreg: 1'b0, regwrite: 1'b0};

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register: asynchronous clear, bubble clears the write-back
// controls while the data fields hold their last values.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_bubble,
  input  logic        i_load_en,
  input  logic [31:0] i_readdata,
  input  logic [31:0] i_aluresult,
  input  logic [4:0]  i_writereg,
  input  wb_ctrl_t    i_ctrl,
  output logic [31:0] o_readdata,
  output logic [31:0] o_aluresult,
  output logic [4:0]  o_writereg,
  output wb_ctrl_t    o_ctrl
);

  logic [31:0] r_readdata;
  logic [31:0] r_aluresult;
  logic [4:0]  r_writereg;
  wb_ctrl_t    r_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata  <= '0;
      r_aluresult <= '0;
      r_writereg  <= '0;
      r_ctrl      <= WB_CTRL_BUBBLE;
    end else if (i_bubble) begin
      r_ctrl <= WB_CTRL_BUBBLE;
    end else begin
      r_aluresult <= i_aluresult;
      r_writereg  <= i_writereg;
      r_ctrl      <= i_ctrl;
      if (i_load_en) r_readdata <= i_readdata;
    end
  end

  assign o_readdata  = r_readdata;
  assign o_aluresult = r_aluresult;
  assign o_writereg  = r_writereg;
  assign o_ctrl      = r_ctrl;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolution toward fetch, req/ack data-memory access with
// pipeline stall, MEM/WB register update and a sticky per-access timeout trap.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcbranch_in,
  input  logic        zero_in,
  input  logic [31:0] aluresult_in,
  input  logic [31:0] rd2_in,
  input  logic [4:0]  writereg_in,
  input  logic        branch_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        memtoreg_in,
  input  logic        regwrite_in,
  output logic        pcsrc,
  output logic [31:0] pcbranch_out,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] readdata_out,
  output logic [31:0] aluresult_out,
  output logic [4:0]  writereg_out,
  output logic        memtoreg_out,
  output logic        regwrite_out,
  output logic        mem_error
);

  localparam int              CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  mem_state_t       r_state;
  mem_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_error;

  logic     w_memop;
  logic     w_is_load;
  logic     w_timeout_hit;
  logic     w_abort;
  logic     w_bubble;
  wb_ctrl_t w_ctrl_in;
  wb_ctrl_t w_ctrl_out;

  assign pcsrc        = branch_in & zero_in;
  assign pcbranch_out = pcbranch_in;

  // A simultaneous read+write request is executed as a store.
  assign w_memop   = memread_in | memwrite_in;
  assign w_is_load = memread_in & ~memwrite_in;

  assign w_timeout_hit = (r_state == ST_WAIT) & w_memop & ~dmem_ack & (r_cnt == TO_VAL);
  assign w_abort       = w_timeout_hit | ((r_state == ST_ERROR) & w_memop);

  assign dmem_req   = w_memop & (r_state != ST_ERROR);
  assign dmem_we    = memwrite_in;
  assign dmem_addr  = aluresult_in;
  assign dmem_wdata = rd2_in;
  assign stall      = dmem_req & ~dmem_ack & ~w_timeout_hit;
  assign w_bubble   = stall | w_abort;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_memop & ~dmem_ack) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (~w_memop | dmem_ack)  w_state_nxt = ST_IDLE;
        else if (r_cnt == TO_VAL) w_state_nxt = ST_ERROR;
      end
      ST_ERROR: w_state_nxt = ST_ERROR;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Counter holds the number of cycles the current request has waited.
      if (w_state_nxt == ST_WAIT)
        r_cnt <= (r_state == ST_WAIT) ? r_cnt + 1'b1 : CNT_W'(1);
      else
        r_cnt <= '0;
      if (w_abort) r_mem_error <= 1'b1;
    end
  end

  assign mem_error = r_mem_error;

  assign w_ctrl_in = '{memtoreg: memtoreg_in, regwrite: regwrite_in};

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .reset       (reset),
    .i_bubble    (w_bubble),
    .i_load_en   (w_is_load),
    .i_readdata  (dmem_rdata),
    .i_aluresult (aluresult_in),
    .i_writereg  (writereg_in),
    .i_ctrl      (w_ctrl_in),
    .o_readdata  (readdata_out),
    .o_aluresult (aluresult_out),
    .o_writereg  (writereg_out),
    .o_ctrl      (w_ctrl_out)
  );

  assign memtoreg_out = w_ctrl_out.memtoreg;
  assign regwrite_out = w_ctrl_out.regwrite;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): ALU pass-through, loads, stores
// with wait states, branch resolution, reset mid-access and timeout trap.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcbranch_in, aluresult_in, rd2_in, dmem_rdata;
  logic [4:0]  writereg_in;
  logic        zero_in, branch_in, memread_in, memwrite_in, memtoreg_in, regwrite_in, dmem_ack;
  logic        pcsrc, stall, dmem_req, dmem_we, memtoreg_out, regwrite_out, mem_error;
  logic [31:0] pcbranch_out, dmem_addr, dmem_wdata, readdata_out, aluresult_out;
  logic [4:0]  writereg_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .pcbranch_in(pcbranch_in), .zero_in(zero_in), .aluresult_in(aluresult_in),
    .rd2_in(rd2_in), .writereg_in(writereg_in), .branch_in(branch_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in),
    .regwrite_in(regwrite_in), .pcsrc(pcsrc), .pcbranch_out(pcbranch_out),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .readdata_out(readdata_out), .aluresult_out(aluresult_out),
    .writereg_out(writereg_out), .memtoreg_out(memtoreg_out),
    .regwrite_out(regwrite_out), .mem_error(mem_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    pcbranch_in = '0; aluresult_in = '0; rd2_in = '0; dmem_rdata = '0;
    writereg_in = '0; zero_in = 0; branch_in = 0; memread_in = 0;
    memwrite_in = 0; memtoreg_in = 0; regwrite_in = 0; dmem_ack = 0;
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    tick();
    tick();
    chk("rst_aluresult", aluresult_out, 32'h0);
    chk("rst_regwrite", regwrite_out, 0);
    chk("rst_readdata", readdata_out, 32'h0);
    chk("rst_mem_error", mem_error, 0);
    reset = 1'b0;

    // ALU op
    aluresult_in = 32'h1234; regwrite_in = 1; writereg_in = 5'd5;
    #1;
    chk("alu_stall", stall, 0);
    chk("alu_req", dmem_req, 0);
    tick();
    chk("alu_result_out", aluresult_out, 32'h1234);
    chk("alu_writereg_out", writereg_out, 32'd5);
    chk("alu_regwrite_out", regwrite_out, 1);

    // Zero-wait load
    clr_in();
    memread_in = 1; memtoreg_in = 1; regwrite_in = 1; writereg_in = 5'd6;
    aluresult_in = 32'h40; dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld0_stall", stall, 0);
    chk("ld0_req", dmem_req, 1);
    chk("ld0_we", dmem_we, 0);
    chk("ld0_addr", dmem_addr, 32'h40);
    tick();
    chk("ld0_readdata", readdata_out, 32'hDEADBEEF);
    chk("ld0_memtoreg", memtoreg_out, 1);
    chk("ld0_writereg", writereg_out, 32'd6);

    // Store with three wait cycles
    clr_in();
    memwrite_in = 1; aluresult_in = 32'h80; rd2_in = 32'd7; writereg_in = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall", stall, 1);
      chk("st_req", dmem_req, 1);
      chk("st_we", dmem_we, 1);
      chk("st_addr", dmem_addr, 32'h80);
      chk("st_wdata", dmem_wdata, 32'd7);
      tick();
      chk("st_wb_regwrite", regwrite_out, 0);
    end
    dmem_ack = 1;
    #1;
    chk("st_ack_stall", stall, 0);
    tick();
    chk("st_done_regwrite", regwrite_out, 0);
    chk("st_done_readdata_hold", readdata_out, 32'hDEADBEEF);
    chk("st_no_error", mem_error, 0);

    // read+write together behaves as a store; readdata must hold
    clr_in();
    memread_in = 1; memwrite_in = 1; dmem_ack = 1; dmem_rdata = 32'h11111111;
    #1;
    chk("rw_we", dmem_we, 1);
    tick();
    chk("rw_readdata_hold", readdata_out, 32'hDEADBEEF);

    // ack without request is ignored
    clr_in();
    dmem_ack = 1; dmem_rdata = 32'h55;
    #1;
    chk("stray_ack_req", dmem_req, 0);
    chk("stray_ack_stall", stall, 0);
    tick();
    chk("stray_ack_readdata", readdata_out, 32'hDEADBEEF);

    // Branch resolution
    clr_in();
    branch_in = 1; zero_in = 1; pcbranch_in = 32'h100;
    #1;
    chk("beq_taken_pcsrc", pcsrc, 1);
    chk("beq_pcbranch", pcbranch_out, 32'h100);
    zero_in = 0;
    #1;
    chk("beq_not_taken_pcsrc", pcsrc, 0);

    // Reset asserted while waiting
    clr_in();
    aluresult_in = 32'h77; regwrite_in = 1; writereg_in = 5'd9;
    tick();
    memread_in = 1; aluresult_in = 32'h44;
    tick();
    tick();
    chk("wait_pre_rst_stall", stall, 1);
    reset = 1'b1;
    clr_in();
    #1;
    chk("rst_wait_aluresult", aluresult_out, 32'h0);
    chk("rst_wait_readdata", readdata_out, 32'h0);
    chk("rst_wait_writereg", writereg_out, 32'h0);
    chk("rst_wait_req", dmem_req, 0);
    chk("rst_wait_stall", stall, 0);
    tick();
    reset = 1'b0;
    memread_in = 1; memtoreg_in = 1; regwrite_in = 1; writereg_in = 5'd4;
    aluresult_in = 32'h48; dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("post_rst_stall", stall, 0);
    tick();
    chk("post_rst_readdata", readdata_out, 32'hCAFEF00D);
    chk("post_rst_regwrite", regwrite_out, 1);

    // Load timeout: 4 stalled cycles, then abort into ERROR
    clr_in();
    memread_in = 1; memtoreg_in = 1; regwrite_in = 1; writereg_in = 5'd9; aluresult_in = 32'h90;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall", stall, 1);
      tick();
      chk("to_wb_regwrite", regwrite_out, 0);
      chk("to_no_error_yet", mem_error, 0);
    end
    #1;
    chk("to_edge_stall", stall, 0);
    chk("to_edge_req", dmem_req, 1);
    tick();
    chk("to_mem_error", mem_error, 1);
    chk("to_bubble_regwrite", regwrite_out, 0);
    chk("to_bubble_memtoreg", memtoreg_out, 0);
    #1;
    chk("err_load_req", dmem_req, 0);
    chk("err_load_stall", stall, 0);
    tick();
    chk("err_load_bubble", regwrite_out, 0);
    chk("err_sticky", mem_error, 1);
    clr_in();
    aluresult_in = 32'hABCD; regwrite_in = 1; writereg_in = 5'd2;
    tick();
    chk("err_alu_result", aluresult_out, 32'hABCD);
    chk("err_alu_regwrite", regwrite_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
